// File: rtl/crc_pkg.sv
// Shared types, presets and helpers for the streaming CRC engine.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } crc_state_t;

    // CRC-8 (plain, non-reflected)
    localparam int         CRC8_PW     = 8;
    localparam logic [7:0] CRC8_POLY   = 8'h07;
    localparam logic [7:0] CRC8_INIT   = 8'h00;
    localparam bit         CRC8_REFIN  = 1'b0;
    localparam bit         CRC8_REFOUT = 1'b0;
    localparam logic [7:0] CRC8_XOROUT = 8'h00;

    // CRC-16/CCITT-FALSE
    localparam int          CRC16_PW     = 16;
    localparam logic [15:0] CRC16_POLY   = 16'h1021;
    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
    localparam bit          CRC16_REFIN  = 1'b0;
    localparam bit          CRC16_REFOUT = 1'b0;
    localparam logic [15:0] CRC16_XOROUT = 16'h0000;

    // CRC-32 (Ethernet / zip)
    localparam int          CRC32_PW     = 32;
    localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
    localparam bit          CRC32_REFIN  = 1'b1;
    localparam bit          CRC32_REFOUT = 1'b1;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

    // Reverses the low 'width' bits of value; bits above width come back as zero.
    function automatic logic [63:0] reflect(input logic [63:0] value, input int width);
        logic [63:0] result;
        result = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < width) begin
                result[6'(i)] = value[6'(width - 1 - i)];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/crc_step.sv
// Combinational CRC advance by BPC message bits, most significant bit first.
module crc_step #(
    parameter int            PW   = 8,
    parameter logic [PW-1:0] POLY = PW'('h07),
    parameter int            BPC  = 1
) (
    input  logic [PW-1:0]  i_crc,
    input  logic [BPC-1:0] i_bits,
    output logic [PW-1:0]  o_crc
);

    logic [PW-1:0] w_acc;
    logic          w_fb;

    // Unrolled serial LFSR: feed each bit from i_bits[BPC-1] down to i_bits[0].
    always_comb begin
        w_acc = i_crc;
        w_fb  = 1'b0;
        for (int k = BPC - 1; k >= 0; k--) begin
            w_fb  = w_acc[PW-1] ^ i_bits[k];
            w_acc = (w_acc << 1) ^ (w_fb ? POLY : '0);
        end
        o_crc = w_acc;
    end

endmodule

// File: rtl/crc_stream.sv
// Multi-beat streaming CRC sink: accepts DW-bit beats, folds BPC bits per
// cycle into a running CRC and offers the finished value on a result handshake.
module crc_stream
    import crc_pkg::*;
#(
    parameter int            DW     = 8,
    parameter int            PW     = 8,
    parameter logic [PW-1:0] POLY   = 8'h07,
    parameter logic [PW-1:0] INIT   = '0,
    parameter logic [PW-1:0] XOROUT = '0,
    parameter bit            REFIN  = 1'b0,
    parameter bit            REFOUT = 1'b0,
    parameter int            BPC    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [PW-1:0] m_crc,
    output logic          busy
);

    localparam int STEPS = DW / BPC;
    localparam int CW    = $clog2(STEPS + 1);

    if (DW % BPC != 0) begin : g_chkDivide
        $error("crc_stream: DW must be a multiple of BPC");
    end
    if (BPC < 1 || BPC > DW) begin : g_chkBpc
        $error("crc_stream: BPC must lie in 1..DW");
    end
    if (REFIN && (DW % 8 != 0)) begin : g_chkRefin
        $error("crc_stream: REFIN needs DW to be a whole number of bytes");
    end
    if (PW < 1 || PW > 64) begin : g_chkPw
        $error("crc_stream: PW must lie in 1..64");
    end

    crc_state_t    r_state;
    logic [PW-1:0] r_crc;
    logic [DW-1:0] r_shReg;
    logic [CW-1:0] r_cnt;
    logic          r_last;
    logic          r_busy;
    logic          r_sReady;
    logic          r_mValid;
    logic [PW-1:0] r_mCrc;

    logic [DW-1:0]  w_inData;
    logic [BPC-1:0] w_stepBits;
    logic [PW-1:0]  w_crcNext;
    logic [PW-1:0]  w_crcOut;

    // Input reflection swaps bits within each byte but keeps byte order.
    if (REFIN) begin : g_refIn
        for (genvar b = 0; b < DW / 8; b++) begin : g_byte
            for (genvar k = 0; k < 8; k++) begin : g_bit
                assign w_inData[8*b + k] = s_data[8*b + 7 - k];
            end
        end
    end else begin : g_noRefIn
        assign w_inData = s_data;
    end

    assign w_stepBits = r_shReg[DW-1 -: BPC];

    crc_step #(
        .PW   (PW),
        .POLY (POLY),
        .BPC  (BPC)
    ) u_step (
        .i_crc  (r_crc),
        .i_bits (w_stepBits),
        .o_crc  (w_crcNext)
    );

    // Final presentation of the CRC finishing in this cycle: optional reversal, then XOROUT.
    always_comb begin
        w_crcOut = (REFOUT ? PW'(reflect(64'(w_crcNext), PW)) : w_crcNext) ^ XOROUT;
    end

    // Control FSM with registered handshake outputs; the running CRC survives between beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_crc    <= INIT;
            r_shReg  <= '0;
            r_cnt    <= '0;
            r_last   <= 1'b0;
            r_busy   <= 1'b0;
            r_sReady <= 1'b1;
            r_mValid <= 1'b0;
            r_mCrc   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (s_valid && r_sReady) begin
                        r_shReg  <= w_inData;
                        r_cnt    <= CW'(STEPS);
                        r_last   <= s_last;
                        r_busy   <= 1'b1;
                        r_sReady <= 1'b0;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_crc   <= w_crcNext;
                    r_shReg <= r_shReg << BPC;
                    r_cnt   <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        if (r_last) begin
                            r_mValid <= 1'b1;
                            r_mCrc   <= w_crcOut;
                            r_state  <= RESP;
                        end else begin
                            r_sReady <= 1'b1;
                            r_state  <= IDLE;
                        end
                    end
                end
                RESP: begin
                    if (m_ready) begin
                        r_crc    <= INIT;
                        r_busy   <= 1'b0;
                        r_mValid <= 1'b0;
                        r_sReady <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s_ready = r_sReady;
    assign m_valid = r_mValid;
    assign m_crc   = r_mCrc;
    assign busy    = r_busy;

endmodule

// File: tb/tb_crc_stream.sv
// Directed bench for crc_stream: five instances covering CRC-8, CRC-16 and
// CRC-32 presets at several beat widths and bits-per-cycle settings.
module tb_crc_stream;
    import crc_pkg::*;

    localparam int NU = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    logic        sValid [NU];
    logic        sLast  [NU];
    logic        mReady [NU];
    logic [31:0] sData  [NU];

    wire         sReadyW [NU];
    wire         mValidW [NU];
    wire         busyW   [NU];
    wire  [31:0] mCrcW   [NU];

    wire  [7:0]  crc0;
    wire  [7:0]  crc1;
    wire  [15:0] crc2;
    wire  [31:0] crc3;
    wire  [31:0] crc4;

    assign mCrcW[0] = {24'd0, crc0};
    assign mCrcW[1] = {24'd0, crc1};
    assign mCrcW[2] = {16'd0, crc2};
    assign mCrcW[3] = crc3;
    assign mCrcW[4] = crc4;

    // Beat accept to s_ready / m_valid, counted in clock edges including the accept edge.
    int expLat [NU] = '{9, 2, 3, 2, 5};

    int nChecks = 0;
    int nFails  = 0;

    crc_stream #(.DW(8), .PW(8), .POLY(CRC8_POLY), .INIT(CRC8_INIT), .XOROUT(CRC8_XOROUT),
                 .REFIN(CRC8_REFIN), .REFOUT(CRC8_REFOUT), .BPC(1)) dut0 (
        .clk(clk), .rst(rst), .s_valid(sValid[0]), .s_ready(sReadyW[0]), .s_data(sData[0][7:0]),
        .s_last(sLast[0]), .m_valid(mValidW[0]), .m_ready(mReady[0]), .m_crc(crc0), .busy(busyW[0]));

    crc_stream #(.DW(8), .PW(8), .POLY(CRC8_POLY), .INIT(CRC8_INIT), .XOROUT(CRC8_XOROUT),
                 .REFIN(CRC8_REFIN), .REFOUT(CRC8_REFOUT), .BPC(8)) dut1 (
        .clk(clk), .rst(rst), .s_valid(sValid[1]), .s_ready(sReadyW[1]), .s_data(sData[1][7:0]),
        .s_last(sLast[1]), .m_valid(mValidW[1]), .m_ready(mReady[1]), .m_crc(crc1), .busy(busyW[1]));

    crc_stream #(.DW(8), .PW(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT), .XOROUT(CRC16_XOROUT),
                 .REFIN(CRC16_REFIN), .REFOUT(CRC16_REFOUT), .BPC(4)) dut2 (
        .clk(clk), .rst(rst), .s_valid(sValid[2]), .s_ready(sReadyW[2]), .s_data(sData[2][7:0]),
        .s_last(sLast[2]), .m_valid(mValidW[2]), .m_ready(mReady[2]), .m_crc(crc2), .busy(busyW[2]));

    crc_stream #(.DW(8), .PW(32), .POLY(CRC32_POLY), .INIT(CRC32_INIT), .XOROUT(CRC32_XOROUT),
                 .REFIN(CRC32_REFIN), .REFOUT(CRC32_REFOUT), .BPC(8)) dut3 (
        .clk(clk), .rst(rst), .s_valid(sValid[3]), .s_ready(sReadyW[3]), .s_data(sData[3][7:0]),
        .s_last(sLast[3]), .m_valid(mValidW[3]), .m_ready(mReady[3]), .m_crc(crc3), .busy(busyW[3]));

    crc_stream #(.DW(32), .PW(32), .POLY(CRC32_POLY), .INIT(CRC32_INIT), .XOROUT(CRC32_XOROUT),
                 .REFIN(CRC32_REFIN), .REFOUT(CRC32_REFOUT), .BPC(8)) dut4 (
        .clk(clk), .rst(rst), .s_valid(sValid[4]), .s_ready(sReadyW[4]), .s_data(sData[4]),
        .s_last(sLast[4]), .m_valid(mValidW[4]), .m_ready(mReady[4]), .m_crc(crc4), .busy(busyW[4]));

    // Independent reflected (LSB-first, 0xEDB88320) CRC-32 over the low nBytes of word, high byte first.
    function automatic logic [31:0] crc32Ref(input logic [31:0] word, input int nBytes);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int b = nBytes - 1; b >= 0; b--) begin
            c = c ^ {24'd0, word[8*b +: 8]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one beat on unit u and checks the accept-to-next-event latency.
    task automatic applyStimulus(input int u, input logic [31:0] data, input logic last);
        int n;
        n = 0;
        while (!sReadyW[u] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) checkOutput($sformatf("u%0d ready timeout", u), 32'd0, 32'd1);
        sData[u]  = data;
        sLast[u]  = last;
        sValid[u] = 1'b1;
        @(posedge clk); #1;
        sValid[u] = 1'b0;
        sData[u]  = 32'hA5A55A5A;
        sLast[u]  = ~last;
        n = 1;
        while (!(sReadyW[u] || mValidW[u]) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput($sformatf("u%0d latency", u), n, expLat[u]);
    endtask

    task automatic takeResult(input int u, input logic [31:0] expected, input string tag);
        int n;
        n = 0;
        while (!mValidW[u] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({tag, " valid"}, {31'd0, mValidW[u]}, 32'd1);
        checkOutput({tag, " busy"}, {31'd0, busyW[u]}, 32'd1);
        checkOutput({tag, " crc"}, mCrcW[u], expected);
        mReady[u] = 1'b1;
        @(posedge clk); #1;
        mReady[u] = 1'b0;
        checkOutput({tag, " done flags"}, {29'd0, busyW[u], mValidW[u], sReadyW[u]}, 32'b001);
    endtask

    task automatic sendString(input int u, input string s, input logic [31:0] expected, input string tag);
        for (int i = 0; i < s.len(); i++) begin
            applyStimulus(u, {24'd0, s[i]}, (i == s.len() - 1));
        end
        takeResult(u, expected, tag);
    endtask

    task automatic checkReset(input int u, input string tag);
        checkOutput($sformatf("%s u%0d flags", tag, u),
                    {29'd0, sReadyW[u], mValidW[u], busyW[u]}, 32'b100);
        checkOutput($sformatf("%s u%0d crc", tag, u), mCrcW[u], 32'd0);
    endtask

    // Main directed sequence.
    initial begin
        string msg;
        msg = "123456789";
        for (int u = 0; u < NU; u++) begin
            sValid[u] = 1'b0;
            sLast[u]  = 1'b0;
            mReady[u] = 1'b0;
            sData[u]  = 32'd0;
        end

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int u = 0; u < NU; u++) checkReset(u, "reset");

        mReady[0] = 1'b1;
        @(posedge clk); #1;
        mReady[0] = 1'b0;
        checkOutput("idle m_ready", {29'd0, busyW[0], mValidW[0], sReadyW[0]}, 32'b001);

        sendString(0, msg, 32'hF4, "crc8 bpc1");
        sendString(1, msg, 32'hF4, "crc8 bpc8");
        sendString(2, msg, 32'h29B1, "crc16 bpc4");
        sendString(3, msg, 32'hCBF43926, "crc32 bpc8");

        applyStimulus(4, 32'h31323334, 1'b0);
        checkOutput("crc32 dw32 mid busy", {31'd0, busyW[4]}, 32'd1);
        applyStimulus(4, 32'h35363738, 1'b1);
        takeResult(4, 32'h9AE0DAAF, "crc32 dw32");
        applyStimulus(4, 32'h00000039, 1'b1);
        takeResult(4, crc32Ref(32'h00000039, 4), "crc32 dw32 fresh");
        applyStimulus(3, 32'h39, 1'b1);
        takeResult(3, crc32Ref(32'h39, 1), "crc32 single byte");

        for (int i = 0; i < 9; i++) applyStimulus(1, {24'd0, msg[i]}, (i == 8));
        sValid[1] = 1'b1;
        sData[1]  = 32'h77;
        sLast[1]  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("hold crc %0d", k), mCrcW[1], 32'hF4);
            checkOutput($sformatf("hold flags %0d", k), {30'd0, mValidW[1], sReadyW[1]}, 32'b10);
        end
        sValid[1] = 1'b0;
        takeResult(1, 32'hF4, "hold release");
        sendString(1, msg, 32'hF4, "after hold");

        for (int i = 0; i < 4; i++) applyStimulus(0, {24'd0, msg[i]}, 1'b0);
        sData[0]  = {24'd0, msg[4]};
        sLast[0]  = 1'b0;
        sValid[0] = 1'b1;
        @(posedge clk); #1;
        sValid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("mid calc busy", {31'd0, busyW[0]}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkReset(0, "mid calc reset");
        sendString(0, msg, 32'hF4, "crc8 after reset");
        sendString(3, msg, 32'hCBF43926, "crc32 after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
